// File: rtl/arb_pkg.sv
// Shared encodings for the instruction/data SRAM arbiter.
// Optional perf counters: MEM_ARB_PERF_CNT_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } arb_owner_e;

  localparam int unsigned WAIT_STATES_DEF = 2;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable 4-bit up/down counter with terminal-count flag,
// used to time SRAM wait states.
module arb_wait_cnt
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = up_i ? cnt_q + 1'b1
                   : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: MEM-stage data access beats fetch.
// Perf counters only when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              perf_clr,
  output logic [31:0]       perf_freeze_cycles,
  output logic [31:0]       perf_data_acc,
  output logic [31:0]       perf_if_acc
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(WAIT_STATES - 1);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic             mem_req;
  logic             in_acc;
  logic             is_data;
  logic             last;
  logic             tc;
  logic [CNT_W-1:0] wait_cnt_unused;

  assign mem_req = mem_r_en | mem_w_en;
  assign in_acc  = (state_q == S_ACCESS);
  assign is_data = (owner_q == OWN_DATA);
  assign last    = in_acc & tc;

  // Counter is held at zero while idle so ACCESS always starts from 0.
  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (state_q == S_IDLE),
    .ld_val_i ('0),
    .en_i     (in_acc),
    .up_i     (1'b1),
    .term_i   (TERM),
    .cnt_o    (wait_cnt_unused),
    .tc_o     (tc)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d = S_ACCESS;
          owner_d = OWN_DATA;
        end else if (if_req) begin
          state_d = S_ACCESS;
          owner_d = OWN_FETCH;
        end
      end
      S_ACCESS: begin
        if (tc) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (1'b1)
      last &  is_data: mem_rdata_d = sram_rdata;
      last & ~is_data: if_rdata_d  = sram_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_DATA;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Requesters hold their bus stable, so the SRAM side is driven live.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    if (in_acc) begin
      if (is_data) begin
        sram_addr  = mem_addr;
        sram_wdata = mem_wdata;
        sram_we    = mem_w_en;
        sram_oe    = ~mem_w_en;
      end else begin
        sram_addr  = if_addr;
        sram_oe    = 1'b1;
      end
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = (state_q == S_DONE) & is_data;
  assign if_ready  = (state_q == S_DONE) & ~is_data;
  assign freeze    = mem_req & ~mem_ready;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] pf_frz_q, pf_frz_d;
  logic [31:0] pf_dat_q, pf_dat_d;
  logic [31:0] pf_if_q,  pf_if_d;

  always_comb begin
    pf_frz_d = pf_frz_q + {31'd0, freeze};
    pf_dat_d = pf_dat_q + {31'd0, mem_ready};
    pf_if_d  = pf_if_q  + {31'd0, if_ready};
    if (perf_clr) begin
      pf_frz_d = '0;
      pf_dat_d = '0;
      pf_if_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_frz_q <= '0;
      pf_dat_q <= '0;
      pf_if_q  <= '0;
    end else begin
      pf_frz_q <= pf_frz_d;
      pf_dat_q <= pf_dat_d;
      pf_if_q  <= pf_if_d;
    end
  end

  assign perf_freeze_cycles = pf_frz_q;
  assign perf_data_acc      = pf_dat_q;
  assign perf_if_acc        = pf_if_q;
`else
  logic perf_clr_unused;
  assign perf_clr_unused    = perf_clr;
  assign perf_freeze_cycles = '0;
  assign perf_data_acc      = '0;
  assign perf_if_acc        = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (WAIT_STATES=2 and 15).
// Perf expectations follow MEM_ARB_PERF_CNT_EN.
module tb_mem_arbiter;

  localparam int W   = 2;
  localparam int LAT = W + 1;
`ifdef MEM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 0;
  logic [31:0] if_addr = 0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_r_en = 0, mem_w_en = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [31:0] mem_rdata;
  logic        mem_ready, freeze;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_we, sram_oe;
  logic [31:0] sram_rdata;
  logic        perf_clr = 0;
  logic [31:0] pf_frz, pf_dat, pf_if;

  logic        if_req_l = 0;
  logic [31:0] if_addr_l = 0;
  logic [31:0] if_rdata_l;
  logic        if_ready_l;
  logic        zero1 = 0;
  logic [31:0] zero32 = 0;
  logic [31:0] mem_rdata_l;
  logic        mem_ready_l, freeze_l;
  logic [31:0] sram_addr_l, sram_wdata_l;
  logic        sram_we_l, sram_oe_l;
  logic [31:0] sram_rdata_l;
  logic [31:0] pf_frz_l, pf_dat_l, pf_if_l;

  mem_arbiter #(.WAIT_STATES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata),
    .perf_clr(perf_clr),
    .perf_freeze_cycles(pf_frz),
    .perf_data_acc(pf_dat), .perf_if_acc(pf_if)
  );

  mem_arbiter #(.WAIT_STATES(15)) u_dut15 (
    .clk(clk), .rst(rst),
    .if_req(if_req_l), .if_addr(if_addr_l),
    .if_rdata(if_rdata_l), .if_ready(if_ready_l),
    .mem_r_en(zero1), .mem_w_en(zero1),
    .mem_addr(zero32), .mem_wdata(zero32),
    .mem_rdata(mem_rdata_l), .mem_ready(mem_ready_l),
    .freeze(freeze_l),
    .sram_addr(sram_addr_l), .sram_wdata(sram_wdata_l),
    .sram_we(sram_we_l), .sram_oe(sram_oe_l),
    .sram_rdata(sram_rdata_l),
    .perf_clr(zero1),
    .perf_freeze_cycles(pf_frz_l),
    .perf_data_acc(pf_dat_l), .perf_if_acc(pf_if_l)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // SRAM model and the bench's own view of memory contents
  logic [31:0] sram_m [logic [31:0]];
  logic [31:0] exp_m  [logic [31:0]];

  function automatic logic [31:0] hashv(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] sram_rd(logic [31:0] a);
    return sram_m.exists(a) ? sram_m[a] : hashv(a);
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    return exp_m.exists(a) ? exp_m[a] : hashv(a);
  endfunction

  always @(negedge clk) begin
    sram_rdata   = sram_rd(sram_addr);
    sram_rdata_l = hashv(sram_addr_l);
  end

  always @(posedge clk)
    if (rst && sram_we) sram_m[sram_addr] = sram_wdata;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          dchk;
  } exp_t;

  exp_t mem_q[$];
  exp_t if_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (mem_ready) begin
      if (mem_q.size() == 0) begin
        chk("mem_ready_spurious", 1, 0);
      end else begin
        e = mem_q.pop_front();
        chk("mem_ready_cyc", cyc, e.cyc);
        if (e.dchk) chk("mem_rdata", mem_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_ready) begin
      if (if_q.size() == 0) begin
        chk("if_ready_spurious", 1, 0);
      end else begin
        e = if_q.pop_front();
        chk("if_ready_cyc", cyc, e.cyc);
        if (e.dchk) chk("if_rdata", if_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mem(bit wr, logic [31:0] a,
                        logic [31:0] d, int dly);
    int n;
    repeat (dly) step();
    mem_addr  = a;
    mem_wdata = d;
    mem_w_en  = wr;
    mem_r_en  = !wr;
    n = 0;
    @(negedge clk);
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready) chk("mem_timeout", 0, 1);
    step();
    mem_r_en = 0;
    mem_w_en = 0;
  endtask

  task automatic do_if(logic [31:0] a, int dly);
    int n;
    repeat (dly) step();
    if_addr = a;
    if_req  = 1;
    n = 0;
    @(negedge clk);
    while (!if_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if_ready) chk("if_timeout", 0, 1);
    step();
    if_req = 0;
  endtask

  task automatic mem_txn(bit wr, logic [31:0] a,
                         logic [31:0] d);
    mem_q.push_back('{cyc + LAT, exp_rd(a), !wr});
    if (wr) exp_m[a] = d;
    do_mem(wr, a, d, 0);
  endtask

  task automatic if_txn(logic [31:0] a);
    if_q.push_back('{cyc + LAT, exp_rd(a), 1'b1});
    do_if(a, 0);
  endtask

  // sel 0: freeze, 1: sram_we; high expected in cycles lo..hi
  task automatic watch(string tag, int sel, int n,
                       int lo, int hi);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, (sel == 0) ? freeze : sram_we,
          (i >= lo && i <= hi) ? 1 : 0);
    end
  endtask

  task automatic chk_perf(string tag, int f, int d, int i);
    chk({tag, "_frz"}, pf_frz, PERF ? f : 0);
    chk({tag, "_dat"}, pf_dat, PERF ? d : 0);
    chk({tag, "_if"},  pf_if,  PERF ? i : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r, prev, n;
    sram_m[32'h10] = 32'hDEAD_BEEF;
    exp_m[32'h10]  = 32'hDEAD_BEEF;

    // reset values
    repeat (3) step();
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_sram_oe", sram_oe, 0);
    chk("rst_freeze", freeze, 0);
    chk_perf("rst_perf", 0, 0, 0);
    rst = 1;
    step();

    // single load
    c0 = cyc;
    mem_q.push_back('{c0 + 3, 32'hDEAD_BEEF, 1'b1});
    fork
      do_mem(0, 32'h10, 0, 0);
      watch("frz_load", 0, 4, 0, 2);
    join
    step();

    // simultaneous store and fetch
    c0 = cyc;
    mem_q.push_back('{c0 + 3, 32'h0, 1'b0});
    exp_m[32'h20] = 32'h5;
    if_q.push_back('{c0 + 7, exp_rd(32'h40), 1'b1});
    fork
      do_mem(1, 32'h20, 32'h5, 0);
      do_if(32'h40, 0);
      watch("sram_we_win", 1, 5, 1, 2);
    join
    step();

    // fetch in flight, load arrives next cycle
    c0 = cyc;
    if_q.push_back('{c0 + 3, exp_rd(32'h44), 1'b1});
    mem_q.push_back('{c0 + 7, exp_rd(32'h20), 1'b1});
    fork
      do_if(32'h44, 0);
      do_mem(0, 32'h20, 0, 1);
      watch("frz_mid_fetch", 0, 8, 1, 6);
    join
    step();

    // reset in the middle of a data access
    mem_addr = 32'h30;
    mem_r_en = 1;
    step();
    step();
    rst = 0;
    #1;
    chk("arst_mem_ready", mem_ready, 0);
    chk("arst_mem_rdata", mem_rdata, 0);
    chk("arst_if_rdata", if_rdata, 0);
    chk("arst_sram_oe", sram_oe, 0);
    chk("arst_sram_addr", sram_addr, 0);
    step();
    step();
    rst = 1;
    r = cyc;
    mem_q.push_back('{r + 3, exp_rd(32'h30), 1'b1});
    repeat (4) step();
    mem_r_en = 0;
    step();

    // perf counters
    perf_clr = 1;
    step();
    perf_clr = 0;
    chk_perf("clr0", 0, 0, 0);
    mem_txn(0, 32'h10, 0);
    mem_txn(0, 32'h44, 0);
    if_txn(32'h50);
    chk_perf("perf", 6, 2, 1);
    perf_clr = 1;
    step();
    perf_clr = 0;
    chk_perf("clr1", 0, 0, 0);

    // WAIT_STATES=15 back-to-back fetches
    if_addr_l = 32'h80;
    if_req_l  = 1;
    c0 = cyc;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!if_ready_l && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!if_ready_l) begin
        chk("if15_timeout", 0, 1);
        break;
      end
      if (k == 0) chk("if15_lat", cyc - c0, 16);
      else        chk("if15_period", cyc - prev, 17);
      prev = cyc;
      chk("if15_rdata", if_rdata_l, hashv(32'h80));
      chk("if15_oe_done", sram_oe_l, 0);
      @(negedge clk);
      chk("if15_oe_idle", sram_oe_l, 0);
      @(negedge clk);
      chk("if15_oe_acc", sram_oe_l, 1);
    end
    if_req_l = 0;
    repeat (20) step();

    chk("mem_q_left", mem_q.size(), 0);
    chk("if_q_left", if_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
